// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART transmit scheduler slice.
//   CPB_115200      : clocks per bit for 115200 baud on the 50 MHz clock
//   UART_FRAME_BITS : 8N1 frame length (start + 8 data + stop)
//   sched_state_t   : scheduler FSM states
//   cnt_width()     : counter width able to hold 0..value-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CPB_115200      = 434;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } sched_state_t;

    // Width of a counter that must reach value-1; never narrower than one bit.
    function automatic int cnt_width(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// 8N1 serialiser. A start pulse while idle latches a byte and sends
// start bit (0), eight data bits LSB first, stop bit (1), each CPB clocks long.
// Ports:
//   clk_50M : system clock (rising edge)
//   rst_n   : asynchronous active-low reset; forces the line high
//   start   : one-cycle request to begin a frame (ignored while sending)
//   data    : byte to send, sampled on the start cycle
//   tx      : registered serial line, idle high
//   done    : registered one-cycle pulse in the last stop-bit cycle
// CPB must be at least 2.
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CPB = CPB_115200
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int               CNT_W    = cnt_width(CPB);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CYC_PRE  = CNT_W'(CPB - 2);
    localparam logic [3:0]       BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic [CNT_W-1:0] cyc_cnt_r;
    logic [3:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             done_r;
    logic             active_r;

    logic             bit_end_s;
    logic             frame_end_s;
    logic             done_next_s;

    // Terminal-count decode; done is predicted one cycle early so it can be registered
    always_comb begin
        bit_end_s   = active_r && (cyc_cnt_r == CYC_LAST);
        frame_end_s = bit_end_s && (bit_cnt_r == BIT_LAST);
        done_next_s = active_r && (bit_cnt_r == BIT_LAST) && (cyc_cnt_r == CYC_PRE);
    end

    // Bit/cycle counters, shift register and the registered line driver
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_r <= '0;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'hFF;
            tx_r      <= 1'b1;
            done_r    <= 1'b0;
            active_r  <= 1'b0;
        end else begin
            done_r <= done_next_s;
            if (start && !active_r) begin
                active_r  <= 1'b1;
                tx_r      <= 1'b0;
                shift_r   <= data;
                cyc_cnt_r <= '0;
                bit_cnt_r <= 4'd0;
            end else if (frame_end_s) begin
                active_r  <= 1'b0;
                tx_r      <= 1'b1;
                cyc_cnt_r <= '0;
                bit_cnt_r <= 4'd0;
            end else if (bit_end_s) begin
                // Ones are shifted in from the top, so after the eighth data
                // bit the next value presented is the stop bit.
                cyc_cnt_r <= '0;
                bit_cnt_r <= bit_cnt_r + 4'd1;
                tx_r      <= shift_r[0];
                shift_r   <= {1'b1, shift_r[7:1]};
            end else if (active_r) begin
                cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
            end else begin
                cyc_cnt_r <= cyc_cnt_r;
            end
        end
    end

    assign tx   = tx_r;
    assign done = done_r;

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART transmit line among NREQ byte requesters. IDLE picks a
// requester, GRANT pulses its ready and latches its byte, SEND runs the
// serialiser for one frame, GAP holds the line idle for IFG extra cycles.
// Ports:
//   clk_50M   : system clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   req_valid : per-requester byte pending
//   req_data  : byte i at [8*i+7:8*i]
//   req_ready : one-cycle pulse on the granted bit during GRANT
//   tx        : serial line, idle high, driven from a register
//   busy      : high from GRANT through the stop bit and any IFG
//   grant_id  : index of the current or last granted requester
//   tx_done   : one-cycle pulse in the last stop-bit cycle
// Build option:
//   UART_SCHED_FIXED_PRIO_EN : lowest index always wins (pointer held at
//                              NREQ-1). Undefined: round-robin.
// -----------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CPB  = CPB_115200,
    parameter int IFG  = 0
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [8*NREQ-1:0]        req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     tx_done
);

    localparam int              ID_W      = $clog2(NREQ);
    localparam logic [ID_W-1:0] PTR_RESET = ID_W'(NREQ - 1);
    localparam int              GAP_W     = cnt_width(IFG);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG > 0) ? (IFG - 1) : 0);

    sched_state_t     state_r;
    sched_state_t     state_next_s;
    logic [ID_W-1:0]  ptr_r;
    logic [ID_W-1:0]  ptr_next_s;
    logic [ID_W-1:0]  grant_id_r;
    logic [ID_W-1:0]  grant_next_s;
    logic [NREQ-1:0]  ready_r;
    logic [NREQ-1:0]  ready_next_s;
    logic             busy_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [GAP_W-1:0] gap_next_s;

    logic             win_found_s;
    logic [ID_W-1:0]  win_idx_s;
    logic             core_start_s;
    logic             core_done_s;
    logic [7:0]       core_data_s;

    // Requester index offset positions after base, wrapping modulo NREQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        return ID_W'((int'(base) + offset) % NREQ);
    endfunction

    // Round-robin search from ptr+1 upward; scanning from the far end lets
    // the nearest requester overwrite earlier candidates.
    always_comb begin
        logic [ID_W-1:0] cand_v;
        cand_v      = '0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_v = rr_index(ptr_r, k);
            if (req_valid[cand_v]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_v;
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Byte of the committed requester, taken while in GRANT
    always_comb begin
        core_data_s = req_data[{grant_id_r, 3'b000} +: 8];
    end

    // Next-state and next-output logic
    always_comb begin
        state_next_s = state_r;
        grant_next_s = grant_id_r;
        ready_next_s = '0;
        ptr_next_s   = ptr_r;
        gap_next_s   = gap_cnt_r;
        core_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_next_s = GRANT;
                    grant_next_s = win_idx_s;
                    ready_next_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT: begin
                core_start_s = 1'b1;
                state_next_s = SEND;
`ifdef UART_SCHED_FIXED_PRIO_EN
                ptr_next_s   = PTR_RESET;
`else
                ptr_next_s   = grant_id_r;
`endif
            end
            SEND: begin
                if (core_done_s) begin
                    if (IFG > 0) begin
                        state_next_s = GAP;
                        gap_next_s   = '0;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    gap_next_s = gap_cnt_r + GAP_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, round-robin pointer and registered handshake/status outputs
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= PTR_RESET;
            grant_id_r <= '0;
            ready_r    <= '0;
            busy_r     <= 1'b0;
            gap_cnt_r  <= '0;
        end else begin
            state_r    <= state_next_s;
            ptr_r      <= ptr_next_s;
            grant_id_r <= grant_next_s;
            ready_r    <= ready_next_s;
            busy_r     <= (state_next_s != IDLE);
            gap_cnt_r  <= gap_next_s;
        end
    end

    uart_tx_core #(
        .CPB (CPB)
    ) u_core (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .start   (core_start_s),
        .data    (core_data_s),
        .tx      (tx),
        .done    (core_done_s)
    );

    assign req_ready = ready_r;
    assign busy      = busy_r;
    assign grant_id  = grant_id_r;
    assign tx_done   = core_done_s;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed stimulus with a transaction-level model: each grant becomes a frame
// record (grant cycle, first start-bit cycle, byte); line, busy, done, ready
// and grant_id are derived from that record by arithmetic on the cycle number
// and compared every cycle. Hand-computed literals pin frame timing, bit
// values and grant order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int NREQ   = 4;
    localparam int CPB    = 434;
    localparam int IFG    = 0;
    localparam int FRAME  = UART_FRAME_BITS * CPB;   // 4340
    localparam int PERIOD = FRAME + 2 + IFG;         // 4342

    logic              clk_50M   = 1'b0;
    logic              rst_n     = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx;
    logic              busy;
    logic [1:0]        grant_id;
    logic              tx_done;

    uart_tx_sched #(
        .NREQ (NREQ),
        .CPB  (CPB),
        .IFG  (IFG)
    ) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .tx_done   (tx_done)
    );

    always #10 clk_50M = ~clk_50M;

    longint cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // bench bookkeeping written by the monitor
    logic [NREQ-1:0] last_ready = '0;
    logic [NREQ-1:0] one_shot   = '0;
    int     g_idx[$];
    longint g_cyc[$];
    int     done_cnt      = 0;
    longint last_done_cyc = -1;
    int     ready0_cnt    = 0;
    int     anomaly_cnt   = 0;

    // model: one frame record plus arbitration pointer
    longint m_fs        = -1000000;
    longint m_idle_from = 0;
    int     m_ptr       = NREQ - 1;
    int     m_gid       = 0;
    logic [7:0] m_byte  = 8'hFF;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int get_gi(input int k);
        return (k < g_idx.size()) ? g_idx[k] : -1;
    endfunction

    function automatic longint get_gc(input int k);
        return (k < g_cyc.size()) ? g_cyc[k] : -1;
    endfunction

    // monitor + model + per-cycle compare, sampled on the falling edge
    initial begin
        logic            exp_tx;
        logic            exp_busy;
        logic            exp_done;
        logic [NREQ-1:0] exp_ready;
        logic [1:0]      exp_gid;
        logic [9:0]      fbits;
        logic [3:0]      pos;
        int              w;
        forever begin
            @(negedge clk_50M);
            last_ready = req_ready;
            if (tx_done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (req_ready[0] === 1'b1) ready0_cnt++;
            if (req_ready !== '0) begin
                w = -1;
                for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i] === 1'b1) w = i;
                g_idx.push_back(w);
                g_cyc.push_back(cyc);
            end
            if (rst_n !== 1'b1) begin
                m_fs        = -1000000;
                m_idle_from = 0;
                m_ptr       = NREQ - 1;
                m_gid       = 0;
            end else begin
                if (cyc == m_fs - 1) m_byte = 8'(req_data >> (8 * m_gid));
                exp_tx = 1'b1;
                if (cyc >= m_fs && cyc < m_fs + FRAME) begin
                    fbits  = {1'b1, m_byte, 1'b0};
                    pos    = 4'((cyc - m_fs) / CPB);
                    exp_tx = fbits[pos];
                end
                exp_busy  = (cyc >= m_fs - 1) && (cyc <= m_fs + FRAME - 1 + IFG);
                exp_done  = (cyc == m_fs + FRAME - 1);
                exp_ready = (cyc == m_fs - 1) ? (NREQ'(1) << m_gid) : '0;
                exp_gid   = 2'(m_gid);
                checks++;
                if (tx !== exp_tx || busy !== exp_busy || tx_done !== exp_done ||
                    req_ready !== exp_ready || grant_id !== exp_gid) begin
                    failures++;
                    $display("FAIL cycle_model c=%0d got/expected tx=%b/%b busy=%b/%b done=%b/%b ready=%b/%b gid=%0d/%0d",
                             cyc, tx, exp_tx, busy, exp_busy, tx_done, exp_done,
                             req_ready, exp_ready, grant_id, exp_gid);
                end
                if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== '0) anomaly_cnt++;
                // arbitration decision on this cycle's requests
                if (req_valid != '0 && cyc >= m_idle_from) begin
                    w = -1;
`ifdef UART_SCHED_FIXED_PRIO_EN
                    for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i]) w = i;
`else
                    for (int k = NREQ; k >= 1; k--) if (req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                    m_ptr = w;
`endif
                    m_gid       = w;
                    m_fs        = cyc + 2;
                    m_idle_from = m_fs + FRAME + IFG;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_50M);
        #1;
        req_valid = req_valid & ~(one_shot & last_ready);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input longint t);
        while (cyc < t) step();
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int used;
        used = 0;
        while (g_idx.size() < n && used < budget) begin
            step();
            used++;
        end
        check(name, longint'(g_idx.size() >= n ? n : g_idx.size()), longint'(n));
    endtask

    task automatic do_reset(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] d, output longint rel);
        rst_n     = 1'b0;
        one_shot  = '0;
        req_valid = v;
        req_data  = d;
        run_cycles(3);
        rst_n = 1'b1;
        rel   = cyc;
        g_idx.delete();
        g_cyc.delete();
        done_cnt    = 0;
        ready0_cnt  = 0;
        anomaly_cnt = 0;
    endtask

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        longint rel;
        longint r0;
        longint fs;
        int     a5_exp [10];
        a5_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // Idle: no requests for 20000 cycles
        do_reset('0, '0, rel);
        check("reset_tx", longint'(tx), 1);
        check("reset_grant_id", longint'(grant_id), 0);
        run_cycles(20000);
        check("idle_anomalies", anomaly_cnt, 0);
        check("idle_grants", g_idx.size(), 0);

        // Requester 0 alone sends 0xA5
        do_reset('0, {8'h00, 8'h00, 8'h00, 8'hA5}, rel);
        one_shot = 4'b0001;
        run_cycles(5);
        r0 = cyc;
        req_valid[0] = 1'b1;
        fs = r0 + 2;
        for (int k = 0; k < 10; k++) begin
            run_to(fs + 217 + 434 * k);
            check($sformatf("a5_bit%0d", k), longint'(tx), a5_exp[k]);
        end
        run_to(fs + FRAME + 10);
        // done is the last of the 4340 frame cycles that begin when tx falls
        check("a5_done_cycle", last_done_cyc, fs + 4339);
        check("a5_done_count", done_cnt, 1);
        check("a5_ready0_count", ready0_cnt, 1);
        check("a5_grant_cycle", get_gc(0), r0 + 1);

`ifndef UART_SCHED_FIXED_PRIO_EN
        // All four held valid from reset: order 0,1,2,3,0 at 4342-cycle spacing
        do_reset(4'hF, {8'h44, 8'h33, 8'h22, 8'h11}, rel);
        wait_grants(5, 5 * PERIOD + 50, "rr_all_grants");
        check("rr_all_first_cycle", get_gc(0), rel + 1);
        check("rr_all_g0", get_gi(0), 0);
        check("rr_all_g1", get_gi(1), 1);
        check("rr_all_g2", get_gi(2), 2);
        check("rr_all_g3", get_gi(3), 3);
        check("rr_all_g4", get_gi(4), 0);
        for (int k = 1; k < 5; k++)
            check($sformatf("rr_all_spacing%0d", k), get_gc(k) - get_gc(k - 1), 4342);
        req_valid = '0;

        // Only requester 2, then 3 and 0 arrive mid-frame: order 2,3,0
        do_reset(4'b0100, {8'h44, 8'h33, 8'h5A, 8'h11}, rel);
        one_shot = '1;
        run_cycles(1000);
        req_valid[3] = 1'b1;
        req_valid[0] = 1'b1;
        wait_grants(3, 3 * PERIOD, "late_grants");
        check("late_g0", get_gi(0), 2);
        check("late_g1", get_gi(1), 3);
        check("late_g2", get_gi(2), 0);
        check("late_spacing", get_gc(2) - get_gc(1), 4342);
        req_valid = '0;
`else
        // Fixed priority: 0 and 1 valid, 0 monopolises until it drops
        do_reset(4'b0011, {8'h44, 8'h33, 8'h22, 8'h11}, rel);
        wait_grants(2, 2 * PERIOD + 50, "fixed_first_grants");
        one_shot = 4'b0001;
        wait_grants(4, 2 * PERIOD + 50, "fixed_more_grants");
        check("fixed_g0", get_gi(0), 0);
        check("fixed_g1", get_gi(1), 0);
        check("fixed_g2", get_gi(2), 0);
        check("fixed_g3", get_gi(3), 1);
        req_valid = '0;
`endif

        // Reset at bit 5 of the second frame, then requester 0 first again
        do_reset(4'hF, {8'h44, 8'h33, 8'h22, 8'h11}, rel);
        fs = rel + 2 + PERIOD;
        run_to(fs + 5 * CPB + 200);
`ifdef UART_SCHED_FIXED_PRIO_EN
        check("abort_pre_gid", get_gi(1), 0);
`else
        check("abort_pre_gid", get_gi(1), 1);
`endif
        check("abort_pre_done", done_cnt, 1);
        rst_n = 1'b0;
        #1;
        check("abort_tx", longint'(tx), 1);
        check("abort_busy", longint'(busy), 0);
        check("abort_ready", longint'(req_ready), 0);
        run_cycles(3);
        check("abort_tx_hold", longint'(tx), 1);
        check("abort_no_done", done_cnt, 1);
        rst_n = 1'b1;
        rel = cyc;
        g_idx.delete();
        g_cyc.delete();
        wait_grants(1, 20, "abort_regrant");
        check("abort_regrant_id", get_gi(0), 0);
        check("abort_regrant_cycle", get_gc(0), rel + 1);
        req_valid = '0;
        run_cycles(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
